// File: rtl/boot_loader_pkg.sv
// Shared command codes, FSM state encoding and load-target helpers for the
// byte-stream program loader.
package boot_loader_pkg;

    localparam logic [7:0] CMD_IMEM = 8'h01;
    localparam logic [7:0] CMD_DMEM = 8'h02;
    localparam logic [7:0] CMD_RF   = 8'h03;
    localparam logic [7:0] CMD_RUN  = 8'hFF;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        RUN  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        TGT_IMEM = 2'd0,
        TGT_DMEM = 2'd1,
        TGT_RF   = 2'd2
    } tgt_t;

    // True for the three commands that carry a header and payload.
    function automatic logic is_load_cmd(input logic [7:0] cmd);
        return (cmd == CMD_IMEM) || (cmd == CMD_DMEM) || (cmd == CMD_RF);
    endfunction

    // Map a load command onto its write target.
    function automatic tgt_t cmd_to_tgt(input logic [7:0] cmd);
        case (cmd)
            CMD_DMEM: return TGT_DMEM;
            CMD_RF:   return TGT_RF;
            default:  return TGT_IMEM;
        endcase
    endfunction

endpackage

// File: rtl/boot_word_pack.sv
// Little-endian 4-byte word assembler with running XOR checksum.
// word_valid pulses for one cycle after the 4th byte of a word is taken;
// word holds the assembled value during that cycle.
module boot_word_pack (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic        lane_last,
    output logic        word_valid,
    output logic [31:0] word,
    output logic [7:0]  csum
);

    logic [1:0]  lane;
    logic [31:0] shreg;

    // Shift bytes in from the top so the first byte lands in bits [7:0].
    always_ff @(posedge clk) begin
        if (!rst) begin
            lane       <= 2'd0;
            shreg      <= 32'd0;
            csum       <= 8'd0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= byte_en && !clr && (lane == 2'd3);
            if (clr) begin
                lane <= 2'd0;
                csum <= 8'd0;
            end else if (byte_en) begin
                lane  <= lane + 2'd1;
                shreg <= {byte_in, shreg[31:8]};
                csum  <= csum ^ byte_in;
            end
        end
    end

    assign lane_last = (lane == 2'd3);
    assign word      = shreg;

endmodule

// File: rtl/boot_loader.sv
// Framed byte-stream loader: parses load commands, writes assembled words to
// instruction memory, data memory or the register file, and holds the core
// in reset until a release command is accepted.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int IMEM_AW = 10,
    parameter int DMEM_AW = 10,
    parameter int RF_AW   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        imem_we,
    output logic        dmem_we,
    output logic        rf_we,
    output logic [15:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        core_rst,
    output logic        load_done,
    output logic        err
);

    localparam logic [15:0] IMEM_MASK = 16'((32'd1 << IMEM_AW) - 32'd1);
    localparam logic [15:0] DMEM_MASK = 16'((32'd1 << DMEM_AW) - 32'd1);
    localparam logic [15:0] RF_MASK   = 16'((32'd1 << RF_AW) - 32'd1);

    // Truncate an address to the width of the selected target so it wraps.
    function automatic logic [15:0] wrap_addr(input logic [15:0] a, input tgt_t t);
        case (t)
            TGT_DMEM: return a & DMEM_MASK;
            TGT_RF:   return a & RF_MASK;
            default:  return a & IMEM_MASK;
        endcase
    endfunction

    state_t      state, state_nxt;
    tgt_t        tgt;
    logic [1:0]  hdr_idx;
    logic [7:0]  adr_lo;
    logic [15:0] cnt_rem;
    logic [15:0] addr;
    logic        rdy_q;
    logic        err_q;
    logic        done_q;
    logic        accept;
    logic        lane_last;
    logic        word_valid;
    logic [31:0] word;
    logic [7:0]  csum;

    assign accept = in_valid && in_ready;

    boot_word_pack u_pack (
        .clk        (clk),
        .rst        (rst),
        .clr        (accept && (state == IDLE)),
        .byte_en    (accept && (state == DATA)),
        .byte_in    (in_data),
        .lane_last  (lane_last),
        .word_valid (word_valid),
        .word       (word),
        .csum       (csum)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state decode; every transition is gated on an accepted byte.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_load_cmd(in_data))                  state_nxt = HDR;
                    else if ((in_data == CMD_RUN) && !err_q)   state_nxt = RUN;
                end
            end
            HDR: begin
                if (accept && (hdr_idx == 2'd3))
                    state_nxt = (cnt_rem == 16'd0) ? CSUM : DATA;
            end
            DATA: begin
                if (accept && lane_last && (cnt_rem == 16'd1)) state_nxt = CSUM;
            end
            CSUM: begin
                if (accept) state_nxt = IDLE;
            end
            RUN:     state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: strobes follow the packer's word_valid; x0 writes are dropped.
    always_comb begin
        in_ready = rdy_q && (state != RUN);
        core_rst = (state != RUN);
        imem_we  = word_valid && (tgt == TGT_IMEM);
        dmem_we  = word_valid && (tgt == TGT_DMEM);
        rf_we    = word_valid && (tgt == TGT_RF) && (addr != 16'd0);
        wr_addr  = addr;
        wr_data  = word;
    end

    // Header capture, address/word counters, sticky error and done pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            tgt     <= TGT_IMEM;
            hdr_idx <= 2'd0;
            adr_lo  <= 8'd0;
            cnt_rem <= 16'd0;
            addr    <= 16'd0;
        end else begin
            rdy_q  <= 1'b1;
            done_q <= 1'b0;
            // Address advances in the write cycle, after it has been presented.
            if (word_valid) addr <= wrap_addr(addr + 16'd1, tgt);
            if (accept) begin
                case (state)
                    IDLE: begin
                        if (is_load_cmd(in_data)) begin
                            tgt     <= cmd_to_tgt(in_data);
                            hdr_idx <= 2'd0;
                        end else if (!((in_data == CMD_RUN) && !err_q)) begin
                            err_q <= 1'b1;
                        end
                    end
                    HDR: begin
                        hdr_idx <= hdr_idx + 2'd1;
                        case (hdr_idx)
                            2'd0:    cnt_rem[7:0]  <= in_data;
                            2'd1:    cnt_rem[15:8] <= in_data;
                            2'd2:    adr_lo        <= in_data;
                            default: addr          <= wrap_addr({in_data, adr_lo}, tgt);
                        endcase
                    end
                    DATA: begin
                        if (lane_last) cnt_rem <= cnt_rem - 16'd1;
                    end
                    CSUM: begin
                        if (in_data == csum) done_q <= 1'b1;
                        else                 err_q  <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign load_done = done_q;
    assign err       = err_q;

endmodule
